// File: rtl/ireg_skew_border_pkg.sv
// Shared constants and helpers for the skewed left-border input register.
// The per-row stage record is declared in skew_stage so it follows WIDTH.
package ireg_pkg;

    localparam logic MODE_SKEW   = 1'b1;
    localparam logic MODE_BYPASS = 1'b0;

    // Number of register stages in row r's chain.
    function automatic int stage_depth(input int r, input int skew);
        return 1 + r * skew;
    endfunction

endpackage

// File: rtl/ireg_skew_border_if.sv
// Controller-side bundle of the border register: control, operand word-set and edge outputs.
interface ireg_skew_border_if #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 4
);
    logic                    en;
    logic                    clr;
    logic                    skew_en;
    logic                    i_valid;
    logic [ROWS*WIDTH-1:0]   i_data;
    logic [ROWS-1:0]         o_valid;
    logic [ROWS*WIDTH-1:0]   o_data;
    logic                    o_busy;
    logic                    o_mode;

    modport master (
        output en, clr, skew_en, i_valid, i_data,
        input  o_valid, o_data, o_busy, o_mode
    );

    modport slave (
        input  en, clr, skew_en, i_valid, i_data,
        output o_valid, o_data, o_busy, o_mode
    );
endinterface

// File: rtl/ireg_skew_border_stage.sv
// One row's delay chain of {valid, data} stages with hold and flush.
// The next-state view is exported so the parent can register occupancy without extra latency.
module skew_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             first_valid,
    output logic [WIDTH-1:0] first_data,
    output logic             last_valid,
    output logic [WIDTH-1:0] last_data,
    output logic             first_valid_next,
    output logic             any_valid_next
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           stage_reg  [DEPTH];
    stage_t           stage_next [DEPTH];
    logic [DEPTH-1:0] valid_next_vec;

    always_comb begin
        stage_next = stage_reg;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage_next[i] = '0;
        end else if (en) begin
            // Invalid entries are forced to zero so an idle array sees zeros.
            stage_next[0].valid = in_valid;
            stage_next[0].data  = in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) stage_next[i] = stage_reg[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_vnext
            assign valid_next_vec[gi] = stage_next[gi].valid;
        end
    endgenerate

    assign first_valid      = stage_reg[0].valid;
    assign first_data       = stage_reg[0].data;
    assign last_valid       = stage_reg[DEPTH-1].valid;
    assign last_data        = stage_reg[DEPTH-1].data;
    assign first_valid_next = valid_next_vec[0];
    assign any_valid_next   = |valid_next_vec;

endmodule

// File: rtl/ireg_skew_border.sv
// Left-border input register of the systolic array: per-row diagonal skew, runtime bypass,
// and registered occupancy so the controller can tell when the wavefront has drained.
module ireg_skew_border
    import ireg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ROWS  = 4,
    parameter int SKEW  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    ireg_skew_border_if.slave  bus
);
    logic                  mode_reg,  mode_next;
    logic                  busy_reg,  busy_next;
    logic [ROWS-1:0]       first_next_vec;
    logic [ROWS-1:0]       any_next_vec;
    logic [ROWS-1:0]       o_valid_w;
    logic [ROWS*WIDTH-1:0] o_data_w;

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic             first_valid, last_valid;
            logic [WIDTH-1:0] first_data,  last_data;

            skew_stage #(
                .WIDTH (WIDTH),
                .DEPTH (stage_depth(gi, SKEW))
            ) u_stage (
                .clk              (clk),
                .rst_n            (rst_n),
                .en               (bus.en),
                .clr              (bus.clr),
                .in_valid         (bus.i_valid),
                .in_data          (bus.i_data[gi*WIDTH +: WIDTH]),
                .first_valid      (first_valid),
                .first_data       (first_data),
                .last_valid       (last_valid),
                .last_data        (last_data),
                .first_valid_next (first_next_vec[gi]),
                .any_valid_next   (any_next_vec[gi])
            );

            assign o_valid_w[gi]                 = (mode_reg == MODE_SKEW) ? last_valid : first_valid;
            assign o_data_w[gi*WIDTH +: WIDTH]   = (mode_reg == MODE_SKEW) ? last_data  : first_data;
        end
    endgenerate

    // A mode switch is only taken when nothing is in flight, so a wavefront is never split.
    always_comb begin
        mode_next = mode_reg;
        if (bus.clr)
            mode_next = bus.skew_en;
        else if (bus.en && !busy_reg && !bus.i_valid)
            mode_next = bus.skew_en;
        busy_next = (mode_next == MODE_SKEW) ? |any_next_vec : |first_next_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= MODE_SKEW;
            busy_reg <= 1'b0;
        end else begin
            mode_reg <= mode_next;
            busy_reg <= busy_next;
        end
    end

    assign bus.o_valid = o_valid_w;
    assign bus.o_data  = o_data_w;
    assign bus.o_busy  = busy_reg;
    assign bus.o_mode  = mode_reg;

endmodule

// File: tb/tb_ireg_skew_border.sv
// Directed self-checking bench for ireg_skew_border (WIDTH=16, ROWS=4, SKEW=1).
module tb_ireg_skew_border;

    localparam int WIDTH = 16;
    localparam int ROWS  = 4;
    localparam int SKEW  = 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ireg_skew_border_if #(.WIDTH(WIDTH), .ROWS(ROWS)) bus ();

    ireg_skew_border #(.WIDTH(WIDTH), .ROWS(ROWS), .SKEW(SKEW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t valid=%b data=%h busy=%b mode=%b", $time,
                 bus.o_valid, bus.o_data, bus.o_busy, bus.o_mode);
    endtask

    task automatic check_out(input string tag, input logic [3:0] v, input logic [63:0] d, input logic b);
        check_eq({tag, "_valid"}, {60'd0, bus.o_valid}, {60'd0, v});
        check_eq({tag, "_data"}, bus.o_data, d);
        check_eq({tag, "_busy"}, {63'd0, bus.o_busy}, {63'd0, b});
    endtask

    task automatic idle_inputs();
        bus.en      = 1'b1;
        bus.clr     = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
    endtask

    task automatic load_abcd();
        bus.i_valid = 1'b1;
        bus.i_data  = 64'h000D_000C_000B_000A;
    endtask

    initial begin
        logic [3:0]  exp_v;
        logic [63:0] exp_d;
        int          w;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.skew_en = 1'b1;
        idle_inputs();
        #12;
        check_out("reset", 4'b0000, 64'h0, 1'b0);
        check_eq("reset_mode", {63'd0, bus.o_mode}, 64'd1);
        rst_n = 1'b1;

        // Test 1: single word-set walks down the diagonal.
        load_abcd();
        step();
        idle_inputs();
        check_out("t1_e1", 4'b0001, 64'h0000_0000_0000_000A, 1'b1);
        step();
        check_out("t1_e2", 4'b0010, 64'h0000_0000_000B_0000, 1'b1);
        step();
        check_out("t1_e3", 4'b0100, 64'h0000_000C_0000_0000, 1'b1);
        step();
        check_out("t1_e4", 4'b1000, 64'h000D_0000_0000_0000, 1'b1);
        step();
        check_out("t1_e5", 4'b0000, 64'h0, 1'b0);

        // Test 2: stall after the second edge freezes the wavefront.
        load_abcd();
        step();
        idle_inputs();
        step();
        check_out("t2_e2", 4'b0010, 64'h0000_0000_000B_0000, 1'b1);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("t2_stall", 4'b0010, 64'h0000_0000_000B_0000, 1'b1);
        end
        bus.en = 1'b1;
        step();
        check_out("t2_e3", 4'b0100, 64'h0000_000C_0000_0000, 1'b1);
        step();
        check_out("t2_e4", 4'b1000, 64'h000D_0000_0000_0000, 1'b1);
        step();
        check_out("t2_e5", 4'b0000, 64'h0, 1'b0);

        // Test 3: clr together with en and a valid word-set flushes everything.
        load_abcd();
        step();
        idle_inputs();
        step();
        check_out("t3_e2", 4'b0010, 64'h0000_0000_000B_0000, 1'b1);
        bus.clr     = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 64'h1111_2222_3333_4444;
        step();
        idle_inputs();
        check_out("t3_clr", 4'b0000, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("t3_after", 4'b0000, 64'h0, 1'b0);
        end

        // Test 4: bypass request held off until the wavefront drains.
        load_abcd();
        bus.skew_en = 1'b0;
        step();
        idle_inputs();
        check_eq("t4_mode_e1", {63'd0, bus.o_mode}, 64'd1);
        step();
        step();
        step();
        check_out("t4_e4", 4'b1000, 64'h000D_0000_0000_0000, 1'b1);
        check_eq("t4_mode_e4", {63'd0, bus.o_mode}, 64'd1);
        step();
        check_eq("t4_busy_e5", {63'd0, bus.o_busy}, 64'd0);
        check_eq("t4_mode_e5", {63'd0, bus.o_mode}, 64'd1);
        step();
        check_eq("t4_mode_e6", {63'd0, bus.o_mode}, 64'd0);
        bus.i_valid = 1'b1;
        bus.i_data  = 64'h001D_001C_001B_001A;
        step();
        idle_inputs();
        check_out("t4_bypass", 4'b1111, 64'h001D_001C_001B_001A, 1'b1);
        step();
        check_out("t4_bypass_idle", 4'b0000, 64'h0, 1'b0);
        // Return to skewed mode through a flush.
        bus.skew_en = 1'b1;
        bus.clr     = 1'b1;
        step();
        idle_inputs();
        check_eq("t4_mode_clr", {63'd0, bus.o_mode}, 64'd1);
        check_out("t4_clr", 4'b0000, 64'h0, 1'b0);

        // Test 5: eight back-to-back word-sets; row r word k carries {r, k}.
        for (int t = 1; t <= 12; t++) begin
            if (t <= 8) begin
                bus.i_valid = 1'b1;
                for (int r = 0; r < ROWS; r++)
                    bus.i_data[r*WIDTH +: WIDTH] = {r[7:0], t[7:0]};
            end else begin
                idle_inputs();
            end
            step();
            exp_v = '0;
            exp_d = '0;
            for (int r = 0; r < ROWS; r++) begin
                w = t - r;
                if (w >= 1 && w <= 8) begin
                    exp_v[r] = 1'b1;
                    exp_d[r*WIDTH +: WIDTH] = {r[7:0], w[7:0]};
                end
            end
            check_out($sformatf("t5_e%0d", t), exp_v, exp_d, (t <= 11));
        end
        idle_inputs();

        // Test 6: asynchronous reset mid-stream while in bypass.
        bus.skew_en = 1'b0;
        bus.clr     = 1'b1;
        step();
        idle_inputs();
        check_eq("t6_mode_bypass", {63'd0, bus.o_mode}, 64'd0);
        for (int t = 1; t <= 3; t++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = {16'h0300, 16'h0200, 16'h0100, 16'h0000} | {4{t[15:0]}};
            step();
            check_out($sformatf("t6_e%0d", t), 4'b1111,
                      {16'h0300, 16'h0200, 16'h0100, 16'h0000} | {4{t[15:0]}}, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t6_async", 4'b0000, 64'h0, 1'b0);
        check_eq("t6_async_mode", {63'd0, bus.o_mode}, 64'd1);
        idle_inputs();
        bus.skew_en = 1'b1;
        #3;
        rst_n = 1'b1;
        step();
        check_out("t6_after", 4'b0000, 64'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
